i2s_transmitter: RTL and testbench



---
 rtl/audio_pkg.sv | 18 +
 rtl/i2s_transmitter.sv | 131 +++++++++++++
 tb/tb_i2s_transmitter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path definitions: transmitter state encoding and sizing helpers.
package audio_pkg;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_RUN  = 1'b1
  } tx_state_t;

  localparam int DEFAULT_DATA_WIDTH = 16;

  // Bit-counter width for a frame of two channel words.
  function automatic int cnt_width(input int data_width);
    return $clog2(2 * data_width);
  endfunction

  localparam int DEFAULT_CNT_WIDTH = cnt_width(DEFAULT_DATA_WIDTH);

endpackage

// File: rtl/i2s_transmitter.sv
// I2S (Philips) stereo transmitter. BCLK, LRCLK and SDATA are registered in the
// system clock domain and advanced by an external bit-clock enable strobe.
// Sample pairs enter through valid/ready into a holding register and are copied
// into the frame shift register at each frame boundary.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   TX_IDLE | pins low, strobes ignored, waiting for i_enable
//   TX_RUN  | each strobe toggles BCLK; falling strobes advance the bit
module i2s_transmitter
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_bclk_en,
  input  logic                  i_enable,
  input  logic [DATA_WIDTH-1:0] i_sample_left,
  input  logic [DATA_WIDTH-1:0] i_sample_right,
  input  logic                  i_sample_valid,
  output logic                  o_sample_ready,
  output logic                  o_i2s_bclk,
  output logic                  o_i2s_lrclk,
  output logic                  o_i2s_sdata,
  output logic                  o_underrun,
  output logic                  o_busy
);

  localparam int FW = 2 * DATA_WIDTH;
  localparam int CW = cnt_width(DATA_WIDTH);

  // Bit index of the last right-channel bit, and the span where LRCLK is high
  // (it leads each channel's MSB by one bit).
  localparam logic [CW-1:0] B_LAST  = CW'(FW - 1);
  localparam logic [CW-1:0] B_LR_LO = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] B_LR_HI = CW'(FW - 2);

  tx_state_t       r_state;
  logic [CW-1:0]   r_b;
  logic [FW-1:0]   r_hold;
  logic            r_hold_full;
  logic [FW-1:0]   r_shift;
  logic            r_bclk;
  logic            r_lrclk;
  logic            r_sdata;
  logic            r_underrun;
  logic            r_busy;

  logic            w_transfer;
  logic [CW-1:0]   w_b_next;

  assign w_transfer = i_sample_valid & ~r_hold_full;
  assign w_b_next   = (r_b == B_LAST) ? '0 : r_b + CW'(1);

  // Control FSM, holding register, shift register and registered pins.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= TX_IDLE;
      r_b         <= B_LAST;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_bclk      <= 1'b0;
      r_lrclk     <= 1'b0;
      r_sdata     <= 1'b0;
      r_underrun  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_underrun <= 1'b0;

      // Transfer only happens with holding empty, so it never collides with
      // the load below clearing a full holding register.
      if (w_transfer) begin
        r_hold      <= {i_sample_left, i_sample_right};
        r_hold_full <= 1'b1;
      end

      case (r_state)
        TX_IDLE: begin
          if (i_enable) begin
            r_state <= TX_RUN;
            r_busy  <= 1'b1;
          end
        end
        TX_RUN: begin
          if (i_bclk_en) begin
            if (!r_bclk) begin
              r_bclk <= 1'b1;
            end else if ((r_b == B_LAST) && !i_enable) begin
              // Stop on the frame boundary; holding contents are kept.
              r_state <= TX_IDLE;
              r_busy  <= 1'b0;
              r_bclk  <= 1'b0;
              r_lrclk <= 1'b0;
              r_sdata <= 1'b0;
            end else begin
              r_bclk  <= 1'b0;
              r_b     <= w_b_next;
              r_lrclk <= (w_b_next >= B_LR_LO) && (w_b_next <= B_LR_HI);
              if (r_b == B_LAST) begin
                // Frame load: no bypass, a pair arriving now waits a frame.
                if (r_hold_full) begin
                  r_shift     <= r_hold << 1;
                  r_sdata     <= r_hold[FW-1];
                  r_hold_full <= 1'b0;
                end else begin
                  r_shift    <= '0;
                  r_sdata    <= 1'b0;
                  r_underrun <= 1'b1;
                end
              end else begin
                r_sdata <= r_shift[FW-1];
                r_shift <= r_shift << 1;
              end
            end
          end
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

  assign o_sample_ready = ~r_hold_full;
  assign o_i2s_bclk     = r_bclk;
  assign o_i2s_lrclk    = r_lrclk;
  assign o_i2s_sdata    = r_sdata;
  assign o_underrun     = r_underrun;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter: W=16 and W=24 instances, strobe every
// 4 clk, SDATA/LRCLK captured at each BCLK rising edge.
module tb_i2s_transmitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n   = 1'b0;
  logic bclk_en = 1'b0;
  int   sc      = 0;

  logic        en16 = 1'b0, v16 = 1'b0;
  logic [15:0] l16 = '0, r16 = '0;
  logic        rdy16, bclk16, lr16, sd16, ur16, busy16;

  logic        en24 = 1'b0, v24 = 1'b0;
  logic [23:0] l24 = '0, r24 = '0;
  logic        rdy24, bclk24, lr24, sd24, ur24, busy24;

  int n_checks = 0;
  int n_errors = 0;

  i2s_transmitter #(.DATA_WIDTH(16)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_bclk_en(bclk_en), .i_enable(en16),
    .i_sample_left(l16), .i_sample_right(r16), .i_sample_valid(v16),
    .o_sample_ready(rdy16), .o_i2s_bclk(bclk16), .o_i2s_lrclk(lr16),
    .o_i2s_sdata(sd16), .o_underrun(ur16), .o_busy(busy16)
  );

  i2s_transmitter #(.DATA_WIDTH(24)) dut24 (
    .i_clk(clk), .i_rst_n(rst_n), .i_bclk_en(bclk_en), .i_enable(en24),
    .i_sample_left(l24), .i_sample_right(r24), .i_sample_valid(v24),
    .o_sample_ready(rdy24), .o_i2s_bclk(bclk24), .o_i2s_lrclk(lr24),
    .o_i2s_sdata(sd24), .o_underrun(ur24), .o_busy(busy24)
  );

  // Bit-clock enable: one cycle in four, driven just after the rising edge.
  always begin
    @(posedge clk);
    #1;
    sc      = (sc + 1) % 4;
    bclk_en = (sc == 0);
  end

  logic sd_q[$], lr_q[$], sd24_q[$], lr24_q[$];
  logic prev16 = 1'b0, prev24 = 1'b0;
  int   ur_hi = 0, rr_run = 0, rr_max = 0;

  always @(negedge clk) begin
    if (bclk16 && !prev16) begin
      sd_q.push_back(sd16);
      lr_q.push_back(lr16);
    end
    prev16 = bclk16;
    if (ur16) ur_hi++;
    if (v16 && rdy16) rr_run++; else rr_run = 0;
    if (rr_run > rr_max) rr_max = rr_run;
  end

  always @(negedge clk) begin
    if (bclk24 && !prev24) begin
      sd24_q.push_back(sd24);
      lr24_q.push_back(lr24);
    end
    prev24 = bclk24;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Leaves the caller at posedge+1 so the next event seen is a falling edge.
  task automatic clear_mon();
    @(posedge clk);
    #1;
    sd_q.delete(); lr_q.delete(); sd24_q.delete(); lr24_q.delete();
    ur_hi = 0; rr_run = 0; rr_max = 0;
  endtask

  function automatic logic [63:0] grab(input bit w24, input bit lr, input int start, input int n);
    logic [63:0] v = '0;
    logic b;
    for (int i = 0; i < n; i++) begin
      if (w24) b = lr ? lr24_q[start+i] : sd24_q[start+i];
      else     b = lr ? lr_q[start+i]   : sd_q[start+i];
      v = {v[62:0], b};
    end
    return v;
  endfunction

  // Must be entered at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
    int i;
    l16 = l; r16 = r; v16 = 1'b1;
    i = 0;
    do begin @(negedge clk); i++; end while (!rdy16 && i < 3000);
    if (!rdy16) chk("xfer_wait", rdy16, 1'b1);
    @(posedge clk);
    #1;
    v16 = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int i = 0;
    do begin @(negedge clk); i++; end while (!rdy16 && i < 3000);
    chk(tag, rdy16, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int i = 0;
    do begin @(negedge clk); i++; end while (busy16 && i < 3000);
    chk(tag, {busy16, bclk16, lr16, sd16}, 4'b0000);
  endtask

  initial begin
    int i;
    repeat (4) @(negedge clk);
    chk("reset_pins", {bclk16, lr16, sd16, ur16, busy16, rdy16}, 6'b000001);
    chk("reset_pins24", {bclk24, lr24, sd24, ur24, busy24, rdy24}, 6'b000001);
    rst_n = 1'b1;

    // Single pair, then stop: one lead-in rise (b=2W-1) plus 32 frame bits.
    clear_mon();
    en16 = 1'b1;
    send_pair(16'hA5A5, 16'h0F0F);
    wait_ready("t1_load");
    en16 = 1'b0;
    wait_idle("t1_idle");
    chk("t1_rises", sd_q.size(), 33);
    chk("t1_leadin", {sd_q[0], lr_q[0]}, 2'b00);
    chk("t1_sdata", grab(0, 0, 1, 32), 64'hA5A5_0F0F);
    chk("t1_lrclk", grab(0, 1, 1, 32), 64'h0001_FFFE);
    chk("t1_underrun", ur_hi, 0);

    // Back-to-back pairs with valid held high.
    clear_mon();
    en16 = 1'b1;
    for (int n = 0; n < 8; n++) begin
      logic [15:0] nn;
      nn = 16'(n);
      l16 = nn; r16 = ~nn; v16 = 1'b1;
      i = 0;
      do begin @(negedge clk); i++; end while (!rdy16 && i < 3000);
      @(posedge clk);
      #1;
    end
    v16 = 1'b0;
    wait_ready("t2_last_load");
    en16 = 1'b0;
    wait_idle("t2_idle");
    chk("t2_rises", sd_q.size(), 257);
    for (int n = 0; n < 8; n++) begin
      logic [15:0] nn;
      nn = 16'(n);
      chk($sformatf("t2_frame%0d", n), grab(0, 0, 1 + 32*n, 32), {32'h0, nn, ~nn});
    end
    chk("t2_underrun", ur_hi, 0);
    chk("t2_ready_run", rr_max, 1);

    // Source stalls after two pairs: third frame zeros with one underrun pulse.
    clear_mon();
    en16 = 1'b1;
    send_pair(16'h1357, 16'h2468);
    send_pair(16'hFFFF, 16'h8001);
    i = 0;
    do begin @(negedge clk); i++; end while (!ur16 && i < 3000);
    chk("t3_ur_seen", ur16, 1'b1);
    en16 = 1'b0;
    wait_idle("t3_idle");
    chk("t3_rises", sd_q.size(), 97);
    chk("t3_frame1", grab(0, 0, 1, 32), 64'h1357_2468);
    chk("t3_frame2", grab(0, 0, 33, 32), 64'hFFFF_8001);
    chk("t3_frame3", grab(0, 0, 65, 32), 64'h0);
    chk("t3_lrclk3", grab(0, 1, 65, 32), 64'h0001_FFFE);
    chk("t3_ur_width", ur_hi, 1);

    // Pair offered on the very edge of a frame load with holding empty.
    clear_mon();
    en16 = 1'b1;
    i = 0;
    do begin @(negedge clk); i++; end
      while (!(sd_q.size() == 33 && bclk16 && bclk_en) && i < 3000);
    chk("t4_sync", sd_q.size(), 33);
    l16 = 16'h1234; r16 = 16'h5678; v16 = 1'b1;
    @(posedge clk);
    #1;
    v16 = 1'b0;
    @(negedge clk);
    chk("t4_edge", {ur16, rdy16}, 2'b10);
    wait_ready("t4_load3");
    en16 = 1'b0;
    wait_idle("t4_idle");
    chk("t4_rises", sd_q.size(), 97);
    chk("t4_frame2", grab(0, 0, 33, 32), 64'h0);
    chk("t4_frame3", grab(0, 0, 65, 32), 64'h1234_5678);
    chk("t4_underrun", ur_hi, 2);

    // Reset at right-channel bit 7 (b=24), then a clean restart.
    clear_mon();
    en16 = 1'b1;
    send_pair(16'hDEAD, 16'hBEEF);
    i = 0;
    do begin @(negedge clk); i++; end while (sd_q.size() < 26 && i < 3000);
    chk("t5_pre_bclk", bclk16, 1'b1);
    rst_n = 1'b0;
    en16  = 1'b0;
    @(negedge clk);
    chk("t5_reset_pins", {bclk16, lr16, sd16, ur16, busy16, rdy16}, 6'b000001);
    rst_n = 1'b1;
    clear_mon();
    en16 = 1'b1;
    send_pair(16'hC3C3, 16'h3C3C);
    wait_ready("t5_load");
    en16 = 1'b0;
    wait_idle("t5_idle");
    chk("t5_rises", sd_q.size(), 33);
    chk("t5_frame", grab(0, 0, 0, 33), 64'h0_C3C3_3C3C);

    // W=24: 48-bit frame, LRCLK high for b=23..46.
    clear_mon();
    en24 = 1'b1;
    l24 = 24'h800001; r24 = 24'h7FFFFE; v24 = 1'b1;
    i = 0;
    do begin @(negedge clk); i++; end while (!rdy24 && i < 3000);
    @(posedge clk);
    #1;
    v24 = 1'b0;
    i = 0;
    do begin @(negedge clk); i++; end while (!rdy24 && i < 3000);
    chk("t6_load", rdy24, 1'b1);
    en24 = 1'b0;
    i = 0;
    do begin @(negedge clk); i++; end while (busy24 && i < 3000);
    chk("t6_idle", {busy24, bclk24, lr24, sd24}, 4'b0000);
    chk("t6_rises", sd24_q.size(), 49);
    chk("t6_sdata", grab(1, 0, 1, 48), 64'h8000_017F_FFFE);
    chk("t6_lrclk", grab(1, 1, 1, 48), 64'h0000_01FF_FFFE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
